// File: rtl/pipelined_addsub_if.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_addsub_if
// Purpose  : Operand/result bundle for pipelined_addsub. It carries the
//            operand channel and the result channel, each with its own
//            valid/ready pair.
// Ports    : master - drives operands and out_ready, receives results
//            slave  - receives operands and out_ready, drives results
// Revision : 1.0 - initial release
// ============================================================================
interface pipelined_addsub_if #(
  parameter int WIDTH = 16
);
  // operand channel
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  // result channel
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf, zero
  );
endinterface
`default_nettype wire

// File: rtl/pipelined_addsub.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_addsub
// Purpose  : Adder/subtractor of WIDTH bits, pipelined as a carry ripple
//            across chunks. Each of STAGES = WIDTH/CHUNK register stages
//            resolves one CHUNK-bit slice and passes its carry to the next
//            stage. The pipeline accepts one operation per clock. A single
//            global advance signal provides full-pipeline backpressure.
// Ports    : clk   - rising-edge clock
//            rst_n - asynchronous active-low reset
//            bus   - pipelined_addsub_if.slave. Its WIDTH must match the
//                    WIDTH of this module.
//                    in_valid/in_ready/a/b/cin/sub   operand channel
//                    out_valid/out_ready/s/cout/ovf/zero result channel
// Params   : WIDTH must be a multiple of CHUNK.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  pipelined_addsub_if.slave  bus
);

  localparam int STAGES = WIDTH / CHUNK;

  // All stages move together. A stage holds its contents, bubbles
  // included, only when the final stage has a result that is not consumed.
  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             carry_first;

  assign adv         = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  // Subtraction is a + ~b + 1. The caller's cin is ignored in that mode.
  assign b_eff       = bus.sub ? ~bus.b : bus.b;
  assign carry_first = bus.sub | bus.cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO  = k * CHUNK;        // first bit resolved here
    localparam int TOP = (k + 1) * CHUNK;  // bits completed after this stage

    // Operand bits not yet consumed, with the current slice in the LSBs.
    logic [WIDTH-LO-1:0] a_src;
    logic [WIDTH-LO-1:0] b_src;
    logic                c_in;
    logic                v_in;
    logic [TOP-1:0]      sum_next;

    logic [CHUNK-1:0]    a_slice;
    logic [CHUNK-1:0]    b_slice;
    logic [CHUNK:0]      chunk_sum;

    logic                valid_d, valid_q;
    logic [TOP-1:0]      sum_d, sum_q;
    logic                carry_d, carry_q;

    if (k == 0) begin : g_first
      assign a_src    = bus.a;
      assign b_src    = b_eff;
      assign c_in     = carry_first;
      assign v_in     = bus.in_valid;  // qualified by adv below
      assign sum_next = chunk_sum[CHUNK-1:0];
    end else begin : g_next
      assign a_src    = g_stage[k-1].g_rem.a_rem_q;
      assign b_src    = g_stage[k-1].g_rem.b_rem_q;
      assign c_in     = g_stage[k-1].carry_q;
      assign v_in     = g_stage[k-1].valid_q;
      assign sum_next = {chunk_sum[CHUNK-1:0], g_stage[k-1].sum_q};
    end

    assign a_slice   = a_src[CHUNK-1:0];
    assign b_slice   = b_src[CHUNK-1:0];
    assign chunk_sum = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, c_in};

    // Data registers update on every advance, whether or not the stage is
    // valid. This keeps the outputs deterministic for bubbles.
    always_comb begin
      valid_d = valid_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      if (adv) begin
        valid_d = v_in;
        sum_d   = sum_next;
        carry_d = chunk_sum[CHUNK];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        sum_q   <= '0;
        carry_q <= 1'b0;
      end else begin
        valid_q <= valid_d;
        sum_q   <= sum_d;
        carry_q <= carry_d;
      end
    end

    if (k < STAGES - 1) begin : g_rem
      localparam int REM = WIDTH - TOP;
      logic [REM-1:0] a_rem_d, a_rem_q;
      logic [REM-1:0] b_rem_d, b_rem_q;

      always_comb begin
        a_rem_d = a_rem_q;
        b_rem_d = b_rem_q;
        if (adv) begin
          a_rem_d = a_src[WIDTH-LO-1:CHUNK];
          b_rem_d = b_src[WIDTH-LO-1:CHUNK];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_rem_q <= '0;
          b_rem_q <= '0;
        end else begin
          a_rem_q <= a_rem_d;
          b_rem_q <= b_rem_d;
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      // The carry into the top bit is recovered from that bit's own sum:
      // c_in(msb) = a(msb) ^ b(msb) ^ s(msb). This works for any CHUNK,
      // including CHUNK = 1.
      logic cmsb_d, cmsb_q;

      always_comb begin
        cmsb_d = cmsb_q;
        if (adv) begin
          cmsb_d = a_slice[CHUNK-1] ^ b_slice[CHUNK-1] ^ chunk_sum[CHUNK-1];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cmsb_q <= 1'b0;
        end else begin
          cmsb_q <= cmsb_d;
        end
      end
    end
  end

  assign bus.out_valid = g_stage[STAGES-1].valid_q;
  assign bus.s         = g_stage[STAGES-1].sum_q;
  assign bus.cout      = g_stage[STAGES-1].carry_q;
  assign bus.ovf       = g_stage[STAGES-1].g_last.cmsb_q ^ g_stage[STAGES-1].carry_q;
  assign bus.zero      = (g_stage[STAGES-1].sum_q == '0);

endmodule
`default_nettype wire
